// File: rtl/static_group_responder.sv
// Group-side endpoint of the static configuration bus: a local bank of
// 32-bit configuration words, plus optional serialization over the group scan chain.
module static_group_responder #(
    parameter logic [1:0]  GROUP_ID  = 2'b00,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SHIFT_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_id,
    input  logic                  static_wen,
    input  logic                  static_ren,
    input  logic [19:0]           static_addr,
    input  logic [31:0]           static_wdata,
    output logic [31:0]           static_rdata,
    output logic                  static_ready,
    output logic                  scan_en,
    output logic                  scan_out,
    input  logic                  scan_in,
    output logic [DEPTH*32-1:0]   cfg_words
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      bank [DEPTH];
    logic [31:0]      shifter;
    logic [31:0]      wdata_q;
    logic             is_write;
    logic [CNT_W-1:0] cnt;

    logic [17:0]   idx_c;
    logic [AW-1:0] widx_c;
    logic          in_range_c;
    logic          req_c;
    logic [31:0]   shifted_c;
    logic [31:0]   reg_rd_c;

    // Request decode and next shifter value
    always_comb begin
        idx_c      = static_addr[17:0];
        widx_c     = idx_c[AW-1:0];
        in_range_c = (idx_c < 18'(DEPTH));
        req_c      = (static_wen | static_ren) && (static_addr[19:18] == GROUP_ID);
        shifted_c  = {scan_in, shifter[31:1]};
        reg_rd_c   = '0;
        if (in_range_c) begin
            reg_rd_c = static_wen ? static_wdata : bank[widx_c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            static_rdata <= '0;
            static_ready <= 1'b0;
            scan_en      <= 1'b0;
            scan_out     <= 1'b0;
            shifter      <= '0;
            wdata_q      <= '0;
            is_write     <= 1'b0;
            cnt          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[AW'(i)] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_c) begin
                        if (static_wen && in_range_c) begin
                            bank[widx_c] <= static_wdata;
                        end
                        wdata_q  <= static_wdata;
                        is_write <= static_wen;
                        if (scan_id) begin
                            shifter  <= static_wen ? static_wdata : 32'h0;
                            scan_out <= static_wen & static_wdata[0];
                            scan_en  <= 1'b1;
                            cnt      <= '0;
                            state    <= SHIFT;
                        end else begin
                            // A pure write leaves rdata alone; wen+ren reports the post-write word
                            if (static_ren) begin
                                static_rdata <= reg_rd_c;
                            end
                            static_ready <= 1'b1;
                            state        <= ACK;
                        end
                    end
                end
                SHIFT: begin
                    shifter <= shifted_c;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        scan_en      <= 1'b0;
                        scan_out     <= 1'b0;
                        static_ready <= 1'b1;
                        static_rdata <= is_write ? wdata_q : shifted_c;
                        state        <= ACK;
                    end else begin
                        scan_out <= shifted_c[0];
                    end
                end
                ACK: begin
                    static_ready <= 1'b0;
                    state        <= RELEASE;
                end
                RELEASE: begin
                    // Hold off until the requester drops, so a held request fires once
                    if (!static_wen && !static_ren) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign cfg_words[32*g +: 32] = bank[g];
        end
    endgenerate

endmodule

// File: tb/tb_static_group_responder.sv
// Directed bench for static_group_responder: register, scan, guard and reset cases.
module tb_static_group_responder;

    localparam int unsigned DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               scan_id;
    logic               static_wen;
    logic               static_ren;
    logic [19:0]        static_addr;
    logic [31:0]        static_wdata;
    logic [31:0]        static_rdata;
    logic               static_ready;
    logic               scan_en;
    logic               scan_out;
    logic               scan_in;
    logic [DEPTH*32-1:0] cfg_words;

    int total = 0;
    int bad   = 0;

    static_group_responder #(.GROUP_ID(2'b00), .DEPTH(DEPTH), .SHIFT_LEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_id      (scan_id),
        .static_wen   (static_wen),
        .static_ren   (static_ren),
        .static_addr  (static_addr),
        .static_wdata (static_wdata),
        .static_rdata (static_rdata),
        .static_ready (static_ready),
        .scan_en      (scan_en),
        .scan_out     (scan_out),
        .scan_in      (scan_in),
        .cfg_words    (cfg_words)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int i);
        return cfg_words[32*i +: 32];
    endfunction

    task automatic idle_bus();
        static_wen   = 1'b0;
        static_ren   = 1'b0;
        scan_id      = 1'b0;
        scan_in      = 1'b0;
    endtask

    // Register access: returns cycles from sampling edge to ready (bounded)
    task automatic reg_req(input logic w, input logic r, input logic [19:0] a,
                           input logic [31:0] d, output int lat);
        scan_id      = 1'b0;
        static_wen   = w;
        static_ren   = r;
        static_addr  = a;
        static_wdata = d;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!static_ready && lat < 50);
        idle_bus();
        step();
        step();
    endtask

    // Scan access: records scan_out per shift cycle, scan_en count and ready cycle
    task automatic scan_req(input logic w, input logic r, input logic [19:0] a,
                            input logic [31:0] d, input logic [31:0] pat,
                            output logic [31:0] so, output int en_cnt, output int rdy_at);
        scan_id      = 1'b1;
        static_wen   = w;
        static_ren   = r;
        static_addr  = a;
        static_wdata = d;
        scan_in      = 1'b0;
        so = '0;
        en_cnt = 0;
        rdy_at = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k <= 32) begin
                so[k-1] = scan_out;
                scan_in = pat[k-1];
            end else begin
                scan_in = 1'b0;
            end
            if (scan_en) en_cnt++;
            if (static_ready && rdy_at == 0) rdy_at = k;
        end
        idle_bus();
        step();
        step();
    endtask

    initial begin
        int          lat;
        int          en_cnt;
        int          rdy_at;
        int          pulses;
        logic [31:0] so;

        rst_n        = 1'b0;
        static_addr  = '0;
        static_wdata = '0;
        idle_bus();
        step();
        step();
        check("rst_ready", 64'(static_ready), 64'd0);
        check("rst_scan_en", 64'(scan_en), 64'd0);
        check("rst_scan_out", 64'(scan_out), 64'd0);
        check("rst_rdata", 64'(static_rdata), 64'd0);
        check("rst_cfg_lo", cfg_words[63:0], 64'd0);
        rst_n = 1'b1;
        step();

        // Register write then read of idx 3
        reg_req(1'b1, 1'b0, 20'd3, 32'hA5A5_1234, lat);
        check("wr3_lat", 64'(lat), 64'd1);
        check("wr3_word", 64'(cfg_words[127:96]), 64'hA5A5_1234);
        reg_req(1'b0, 1'b1, 20'd3, 32'h0, lat);
        check("rd3_lat", 64'(lat), 64'd1);
        check("rd3_data", 64'(static_rdata), 64'hA5A5_1234);

        // Scan write to idx 0
        scan_req(1'b1, 1'b0, 20'd0, 32'h8000_0001, 32'h0, so, en_cnt, rdy_at);
        check("sw_scan_out", 64'(so), 64'h8000_0001);
        check("sw_en_cnt", 64'(en_cnt), 64'd32);
        check("sw_ready_at", 64'(rdy_at), 64'd33);
        check("sw_word0", 64'(word(0)), 64'h8000_0001);
        check("sw_rdata", 64'(static_rdata), 64'h8000_0001);

        // Scan read of idx 3 with chain returning 1,0,1,1,0...
        scan_req(1'b0, 1'b1, 20'd3, 32'hFFFF_FFFF, 32'h0000_000D, so, en_cnt, rdy_at);
        check("sr_rdata", 64'(static_rdata), 64'h0000_000D);
        check("sr_ready_at", 64'(rdy_at), 64'd33);
        check("sr_scan_out", 64'(so), 64'h0);
        check("sr_word3", 64'(word(3)), 64'hA5A5_1234);

        // Held read request yields one ready pulse
        scan_id     = 1'b0;
        static_ren  = 1'b1;
        static_addr = 20'd3;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (static_ready) pulses++;
        end
        idle_bus();
        step();
        step();
        check("held_pulses", 64'(pulses), 64'd1);
        check("held_rdata", 64'(static_rdata), 64'hA5A5_1234);

        // Wrong group: no ready, no write
        static_wen   = 1'b1;
        static_addr  = {2'b01, 18'd3};
        static_wdata = 32'hFFFF_FFFF;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (static_ready) pulses++;
        end
        idle_bus();
        step();
        check("wg_pulses", 64'(pulses), 64'd0);
        check("wg_word3", 64'(word(3)), 64'hA5A5_1234);

        // Out-of-range read and write
        reg_req(1'b0, 1'b1, 20'(DEPTH), 32'h0, lat);
        check("oor_rd_lat", 64'(lat), 64'd1);
        check("oor_rd_data", 64'(static_rdata), 64'd0);
        reg_req(1'b1, 1'b0, 20'(DEPTH), 32'h1234_5678, lat);
        check("oor_wr_lat", 64'(lat), 64'd1);
        check("oor_wr_bank", cfg_words[255:192], {word(7), word(6)});
        check("oor_wr_w7", 64'(word(7)), 64'd0);

        // Simultaneous wen/ren is a write
        reg_req(1'b1, 1'b1, 20'd1, 32'hCAFE_F00D, lat);
        check("wr_rd_lat", 64'(lat), 64'd1);
        check("wr_rd_rdata", 64'(static_rdata), 64'hCAFE_F00D);
        check("wr_rd_word1", 64'(word(1)), 64'hCAFE_F00D);

        // Reset during shift cycle 10
        scan_id      = 1'b1;
        static_wen   = 1'b1;
        static_addr  = 20'd2;
        static_wdata = 32'hFFFF_FFFF;
        for (int k = 1; k <= 10; k++) step();
        check("mid_scan_en", 64'(scan_en), 64'd1);
        rst_n = 1'b0;
        step();
        check("rst_mid_scan_en", 64'(scan_en), 64'd0);
        check("rst_mid_scan_out", 64'(scan_out), 64'd0);
        check("rst_mid_ready", 64'(static_ready), 64'd0);
        check("rst_mid_cfg_hi", cfg_words[255:128], 128'd0);
        check("rst_mid_cfg_lo", cfg_words[127:0], 128'd0);
        rst_n = 1'b1;
        idle_bus();
        step();
        reg_req(1'b1, 1'b0, 20'd5, 32'h0BAD_BEEF, lat);
        check("post_rst_wr_lat", 64'(lat), 64'd1);
        reg_req(1'b0, 1'b1, 20'd5, 32'h0, lat);
        check("post_rst_rd_lat", 64'(lat), 64'd1);
        check("post_rst_rdata", 64'(static_rdata), 64'h0BAD_BEEF);
        check("post_rst_word2", 64'(word(2)), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
